rv32_mod_muldiv: RTL and testbench
==================================

RV32_MOD_MULDIV -- requirements
Module: rv32_mod_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (even, >= 8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port func  input  3  RISC-V M-extension funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 SHALL have port op_a  input  XLEN  rs1 operand (multiplicand/dividend).
REQ-008 SHALL have port op_b  input  XLEN  rs2 operand (multiplier/divisor).
REQ-009 SHALL have port kill  input  1  synchronous abort of the in-flight operation (pipeline flush).
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  XLEN  operation result.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement the state machine IDLE -> BUSY -> DONE -> IDLE.
REQ-015 SHALL drive in_ready high exactly when state is IDLE; accept occurs on in_valid && in_ready, latching func, op_a and op_b.
REQ-016 SHALL compute all ops on magnitudes with a 1-bit-per-cycle unsigned shift-add (MUL*) or restoring shift-subtract (DIV*/REM*) core, then apply sign correction in the final cycle.
REQ-017 SHALL assert out_valid exactly XLEN+1 cycles after the accept edge for normal operations.
REQ-018 SHALL, for divisor == 0, bypass iteration and assert out_valid 1 cycle after accept: DIV/DIVU -> all ones; REM/REMU -> op_a.
REQ-019 SHALL, for DIV/REM with op_a = -2^(XLEN-1) and op_b = -1, bypass iteration (1-cycle latency): DIV -> -2^(XLEN-1); REM -> 0.
REQ-020 SHALL return the low XLEN bits of the 2*XLEN product for MUL, and the high XLEN bits for MULH (s*s), MULHSU (s*u) and MULHU (u*u).
REQ-021 SHALL truncate quotients toward zero; remainder sign SHALL equal the dividend sign.
REQ-022 SHALL hold result and out_valid stable in DONE until out_ready is high; on that edge it SHALL return to IDLE.
REQ-023 SHALL NOT accept a new request in DONE (no overlap); the next accept is possible at the earliest in the cycle after the handshake.
REQ-024 SHALL, on kill high, go to IDLE on the next edge from any state, drop out_valid, and discard the result; kill SHALL take priority over a same-cycle accept, and that request SHALL NOT be latched.
REQ-025 SHALL ignore func, op_a and op_b outside the accept cycle.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force state IDLE, out_valid 0, result 0, busy 0, and clear all iteration counters and registers.
REQ-027 SHALL drive in_ready 1 from the first edge after rst_n deasserts; reset mid-operation SHALL abandon the operation with no out_valid.

Structure
REQ-028 SHALL take the muldiv_op_e enum (8 funct3 codes) and the state enum from shared package rv32_pkg.
REQ-029 SHALL instantiate a single sub-module, rv32_mod_muldiv_iter, holding the XLEN-step unsigned shift-add/subtract datapath and its step counter; sign handling and the handshake FSM remain in the top level.

Verification (XLEN=32)
REQ-030 SHALL check: MUL 7 * 0xFFFFFFFD -> 0xFFFFFFEB, with out_valid exactly 33 cycles after accept.
REQ-031 SHALL check: op_a=op_b=0xFFFFFFFF gives MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF.
REQ-032 SHALL check: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-033 SHALL check, each with a 1-cycle latency: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-034 SHALL check: with out_ready held low 5 cycles after out_valid, result stays stable and in_ready stays 0; the handshake is followed by in_ready 1 on the next cycle.
REQ-035 SHALL check: kill 10 cycles into a DIV -> IDLE next cycle with no out_valid; kill together with in_valid in IDLE -> nothing latched; rst_n low mid-MUL -> all outputs at reset values immediately.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32 M-extension multiply/divide unit.
//   muldiv_op_e    : RISC-V funct3 encodings of the eight M-extension ops
//   muldiv_state_e : handshake FSM states of rv32_mod_muldiv
//   op_a_signed / op_b_signed : which operands are treated as two's complement
package rv32_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  // MUL keeps only the low product half, which is sign-agnostic, so it is
  // run as unsigned.
  function automatic logic op_a_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/rv32_mod_muldiv_iter.sv
// Unsigned iterative core: one bit per cycle, XLEN steps.
//   start       : load magnitudes and restart the step counter
//   clear       : abandon the running iteration
//   is_div      : 1 = restoring shift-subtract, 0 = shift-add multiply
//   a_mag/b_mag : unsigned operand magnitudes (rs1 / rs2)
//   hi/lo       : multiply -> {hi,lo} is the 2*XLEN product
//                 divide   -> lo is the quotient, hi the remainder
//   done        : all XLEN steps complete, hi/lo hold the final values
import rv32_pkg::*;

module rv32_mod_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            clear,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            done
);

  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   count;
  logic            active;
  logic            div_q;
  logic [XLEN-1:0] b_q;      // multiplicand (mul) or divisor (div)
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   sub_in;
  logic [XLEN:0]   sub_diff;
  logic            sub_ok;
  logic [XLEN-1:0] hi_nxt;
  logic [XLEN-1:0] lo_nxt;
  logic            step;

  assign step = active && (count != CW'(XLEN));
  assign done = active && (count == CW'(XLEN));

  always_comb begin
    add_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    sub_in   = {hi, lo[XLEN-1]};
    sub_diff = sub_in - {1'b0, b_q};
    // Partial remainder is always < 2*divisor, so the top bit of the
    // difference is a clean borrow flag.
    sub_ok   = !sub_diff[XLEN];
    if (div_q) begin
      hi_nxt = sub_ok ? sub_diff[XLEN-1:0] : sub_in[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], sub_ok};
    end else begin
      // {carry,hi,lo} shifted right by one after the conditional add
      hi_nxt = add_sum[XLEN:1];
      lo_nxt = {add_sum[0], lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      active <= 1'b0;
      div_q  <= 1'b0;
      b_q    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (clear) begin
      count  <= '0;
      active <= 1'b0;
    end else if (start) begin
      count  <= '0;
      active <= 1'b1;
      div_q  <= is_div;
      hi     <= '0;
      lo     <= is_div ? a_mag : b_mag;
      b_q    <= is_div ? b_mag : a_mag;
    end else if (step) begin
      count  <= count + 1'b1;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
    end
  end

endmodule

// File: rtl/rv32_mod_muldiv.sv
// RV32 M-extension multiply/divide unit with valid/ready handshakes.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : request handshake; func/op_a/op_b sampled on accept
//   kill                 : synchronous abort, returns to IDLE from any state
//   out_valid/out_ready  : result handshake; result held until accepted
//   busy                 : state is not IDLE
//   state_dbg            : current FSM state for observation
// Handshake rule: a transfer happens on a rising edge where valid && ready;
// the producer holds its payload stable until then, and ready never depends
// on valid.
// Operations run on magnitudes in rv32_mod_muldiv_iter (XLEN cycles) and get
// their sign fixed in one extra cycle, so normal latency is XLEN+1. Divide by
// zero and signed overflow skip the core and finish one cycle after accept.
import rv32_pkg::*;

module rv32_mod_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output muldiv_state_e   state_dbg
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e state, state_nxt;

  // request decode (combinational on the input bus)
  muldiv_op_e      op_in;
  logic            neg_a_in, neg_b_in, is_div_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic            b_zero_in, ovf_in, byp_in;
  logic [XLEN-1:0] byp_val_in;
  logic            accept;

  // latched request
  muldiv_op_e      op_q;
  logic            neg_a_q, neg_b_q, byp_q;
  logic [XLEN-1:0] byp_val_q;

  // core and sign correction
  logic [XLEN-1:0]   iter_hi, iter_lo;
  logic              iter_done;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, corrected;
  logic              finish;

  assign op_in      = muldiv_op_e'(func);
  assign neg_a_in   = op_a_signed(op_in) && op_a[XLEN-1];
  assign neg_b_in   = op_b_signed(op_in) && op_b[XLEN-1];
  assign mag_a_in   = neg_a_in ? (~op_a + 1'b1) : op_a;
  assign mag_b_in   = neg_b_in ? (~op_b + 1'b1) : op_b;
  assign is_div_in  = func[2];
  assign b_zero_in  = (op_b == '0);
  assign ovf_in     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                      (op_a == MIN_INT) && (op_b == '1);
  assign byp_in     = is_div_in && (b_zero_in || ovf_in);
  // func[1] separates REM* from DIV*. Overflow quotient equals op_a.
  assign byp_val_in = b_zero_in ? (func[1] ? op_a : '1)
                                : (func[1] ? '0 : op_a);

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;
  assign accept    = in_valid && in_ready && !kill;

  rv32_mod_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && !byp_in),
    .clear  (kill),
    .is_div (is_div_in),
    .a_mag  (mag_a_in),
    .b_mag  (mag_b_in),
    .hi     (iter_hi),
    .lo     (iter_lo),
    .done   (iter_done)
  );

  always_comb begin
    prod_s = (neg_a_q ^ neg_b_q) ? (~{iter_hi, iter_lo} + 1'b1) : {iter_hi, iter_lo};
    quo_s  = (neg_a_q ^ neg_b_q) ? (~iter_lo + 1'b1) : iter_lo;
    rem_s  = neg_a_q ? (~iter_hi + 1'b1) : iter_hi;
    case (op_q)
      OP_MUL:                       corrected = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: corrected = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              corrected = quo_s;
      default:                      corrected = rem_s;
    endcase
  end

  assign finish = (state == ST_BUSY) && (byp_q || iter_done) && !kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_BUSY;
      ST_BUSY: if (finish)    state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
    if (kill) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_MUL;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      byp_q     <= 1'b0;
      byp_val_q <= '0;
      result    <= '0;
    end else begin
      if (accept) begin
        op_q      <= op_in;
        neg_a_q   <= neg_a_in;
        neg_b_q   <= neg_b_in;
        byp_q     <= byp_in;
        byp_val_q <= byp_val_in;
      end
      if (kill)        result <= '0;
      else if (finish) result <= byp_q ? byp_val_q : corrected;
    end
  end

endmodule

// File: tb/tb_rv32_mod_muldiv.sv
module tb_rv32_mod_muldiv;
  import rv32_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  func;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;
  muldiv_state_e state_dbg;

  int checks = 0;
  int errors = 0;

  rv32_mod_muldiv #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func      (func),
    .op_a      (op_a),
    .op_b      (op_b),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Present one request in IDLE; returns #1 after the accept edge with the
  // operand bus scrambled so later sampling would be visible.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1; func = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    func = 3'($urandom_range(0, 7)); op_a = $urandom; op_b = $urandom;
  endtask

  // Counts rising edges until out_valid; lat is 100 on timeout.
  task automatic wait_result(output logic [31:0] r, output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result;
  endtask

  task automatic handshake();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; func = '0; op_a = '0; op_b = '0;
    kill = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ov=%b res=%h busy=%b exp ov=0 res=0 busy=0", out_valid, result, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat;
    issue(3'b000, 32'd7, 32'hFFFF_FFFD);
    wait_result(r, lat);
    checks++;
    if (r !== 32'hFFFF_FFEB) begin
      errors++; $display("FAIL mul_result got %h exp ffffffeb", r);
    end
    checks++;
    if (lat !== 33) begin
      errors++; $display("FAIL mul_latency got %0d exp 33", lat);
    end
    handshake();
  endtask

  task automatic test_mulh_variants();
    logic [2:0]  fv [3];
    logic [31:0] ev [3];
    logic [31:0] r; int lat;
    fv[0] = 3'b011; ev[0] = 32'hFFFF_FFFE;  // MULHU
    fv[1] = 3'b001; ev[1] = 32'h0000_0000;  // MULH
    fv[2] = 3'b010; ev[2] = 32'hFFFF_FFFF;  // MULHSU
    for (int i = 0; i < 3; i++) begin
      issue(fv[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_result(r, lat);
      checks++;
      if (r !== ev[i] || lat !== 33) begin
        errors++;
        $display("FAIL mulh_f%0d got %h lat %0d exp %h lat 33", fv[i], r, lat, ev[i]);
      end
      handshake();
    end
  endtask

  task automatic test_div_rem();
    logic [2:0]  fv [4];
    logic [31:0] av [4];
    logic [31:0] bv [4];
    logic [31:0] ev [4];
    logic [31:0] r; int lat;
    fv[0] = 3'b100; av[0] = 32'hFFFF_FFF9; bv[0] = 32'd2; ev[0] = 32'hFFFF_FFFD;
    fv[1] = 3'b110; av[1] = 32'hFFFF_FFF9; bv[1] = 32'd2; ev[1] = 32'hFFFF_FFFF;
    fv[2] = 3'b101; av[2] = 32'd100;       bv[2] = 32'd7; ev[2] = 32'd14;
    fv[3] = 3'b111; av[3] = 32'd100;       bv[3] = 32'd7; ev[3] = 32'd2;
    for (int i = 0; i < 4; i++) begin
      issue(fv[i], av[i], bv[i]);
      wait_result(r, lat);
      checks++;
      if (r !== ev[i] || lat !== 33) begin
        errors++;
        $display("FAIL divrem_%0d got %h lat %0d exp %h lat 33", i, r, lat, ev[i]);
      end
      handshake();
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  fv [4];
    logic [31:0] av [4];
    logic [31:0] bv [4];
    logic [31:0] ev [4];
    logic [31:0] r; int lat;
    fv[0] = 3'b101; av[0] = 32'd5;         bv[0] = 32'd0;         ev[0] = 32'hFFFF_FFFF;
    fv[1] = 3'b110; av[1] = 32'd5;         bv[1] = 32'd0;         ev[1] = 32'd5;
    fv[2] = 3'b100; av[2] = 32'h8000_0000; bv[2] = 32'hFFFF_FFFF; ev[2] = 32'h8000_0000;
    fv[3] = 3'b110; av[3] = 32'h8000_0000; bv[3] = 32'hFFFF_FFFF; ev[3] = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      issue(fv[i], av[i], bv[i]);
      wait_result(r, lat);
      checks++;
      if (r !== ev[i] || lat !== 1) begin
        errors++;
        $display("FAIL special_%0d got %h lat %0d exp %h lat 1", i, r, lat, ev[i]);
      end
      handshake();
    end
  endtask

  task automatic test_stall();
    logic [31:0] r; int lat; int bad;
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result(r, lat);
    checks++;
    if (r !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL stall_result got %h exp fffffffe", r);
    end
    // a competing request must not be taken while the result is pending
    bad = 0;
    @(negedge clk); in_valid = 1'b1; func = 3'b000; op_a = 32'd3; op_b = 32'd4;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (result !== 32'hFFFF_FFFE || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold got %0d bad cycles (res=%h ov=%b rdy=%b) exp 0", bad, result, out_valid, in_ready);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_release got rdy=%b busy=%b exp rdy=1 busy=0", in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat;
    issue(3'b000, 32'd6, 32'd7);
    wait_result(r, lat);
    handshake();
    issue(3'b000, 32'hFFFF_FFFF, 32'd5);  // accepted on the edge after the handshake
    wait_result(r, lat);
    checks++;
    if (r !== 32'hFFFF_FFFB || lat !== 33) begin
      errors++; $display("FAIL back_to_back got %h lat %0d exp fffffffb lat 33", r, lat);
    end
    handshake();
  endtask

  task automatic test_kill();
    logic [31:0] r; int lat; int seen;
    issue(3'b100, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL kill_busy got busy=%b ov=%b rdy=%b exp 0 0 1", busy, out_valid, in_ready);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL kill_no_out got %0d valid cycles exp 0", seen);
    end
    // kill wins over a simultaneous request
    @(negedge clk); in_valid = 1'b1; kill = 1'b1; func = 3'b110; op_a = 32'd9; op_b = 32'd0;
    @(posedge clk); #1; in_valid = 1'b0; kill = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy || out_valid || !in_ready) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL kill_accept got %0d non-idle cycles exp 0", seen);
    end
    issue(3'b101, 32'd77, 32'd7);
    wait_result(r, lat);
    checks++;
    if (r !== 32'd11 || lat !== 33) begin
      errors++; $display("FAIL after_kill got %h lat %0d exp 0000000b lat 33", r, lat);
    end
    handshake();
  endtask

  task automatic test_reset_mid_op();
    int seen;
    // result register holds 11 from the previous op at this point
    issue(3'b000, 32'd12345, 32'd678);
    repeat (5) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 32'h0) begin
      errors++; $display("FAIL reset_mid got busy=%b ov=%b res=%h exp 0 0 0", busy, out_valid, result);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_abandon got %0d active cycles rdy=%b exp 0 rdy=1", seen, in_ready);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mul();
    test_mulh_variants();
    test_div_rem();
    test_div_special();
    test_stall();
    test_back_to_back();
    test_kill();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
